// File: rtl/dcache_ctrl_pkg.sv
// Shared types and address-field constants for the direct-mapped data cache controller.
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = 2;
  localparam int OFFSET_LSB  = 1;
  localparam int INDEX_LSB   = OFFSET_LSB + OFFSET_BITS;

  function automatic int tag_bits(input int index_bits);
    return ADDR_W - INDEX_LSB - index_bits;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Memory-stage request/response and backing-memory handshake bundle.
interface dcache_ctrl_if;
  import dcache_ctrl_pkg::*;

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              stall;
  logic              hit;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  rd, wr, addr, wdata, mem_ack, mem_rdata,
    output rdata, done, stall, hit, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd, wr, addr, wdata, mem_ack, mem_rdata,
    input  rdata, done, stall, hit, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl_array.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous writes.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TAG_W      = tag_bits(INDEX_BITS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [INDEX_BITS-1:0]                 idx,
  output logic [TAG_W-1:0]                      rd_tag,
  output logic                                  rd_valid,
  output logic                                  rd_dirty,
  output logic [LINE_WORDS-1:0][DATA_W-1:0]     rd_line,
  input  logic                                  word_we,
  input  logic [OFFSET_BITS-1:0]                wr_off,
  input  logic [DATA_W-1:0]                     wr_data,
  input  logic                                  tag_we,
  input  logic [TAG_W-1:0]                      wr_tag,
  input  logic                                  set_dirty
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINE_WORDS-1:0][DATA_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    // A tag write marks the line freshly refilled, hence clean.
    if (tag_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
    if (set_dirty) dirty_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) data_q[idx][wr_off] <= wr_data;
    if (tag_we)  tag_q[idx]          <= wr_tag;
  end

  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_line  = data_q[idx];
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller with line writeback/refill FSM.
//   state  | meaning
//   S_IDLE | combinational lookup; hit completes, miss latches request
//   S_WB   | write dirty victim line to memory, one word per ack
//   S_FILL | read requested line from memory, one word per ack
//   S_DONE | complete the access from the refilled line
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS  = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  dcache_ctrl_if.slave  bus
);
  localparam int TAG_W  = tag_bits(INDEX_BITS);
  localparam int IDX_LO = OFFSET_BITS;
  localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]       TMO_LOAD  = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(LINE_WORDS - 1);

  state_t                  state_q, state_d;
  logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    err_q, err_d;
  logic [ADDR_W-2:0]       addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;

  logic [ADDR_W-2:0]       cur_word;
  logic [OFFSET_BITS-1:0]  cur_off;
  logic [INDEX_BITS-1:0]   cur_idx;
  logic [TAG_W-1:0]        cur_tag;
  logic [TAG_W-1:0]        a_tag;
  logic                    a_valid, a_dirty;
  logic [LINE_WORDS-1:0][DATA_W-1:0] a_line;

  logic                    word_we, tag_we, set_dirty, req_bad;
  logic [OFFSET_BITS-1:0]  wr_off;
  logic [DATA_W-1:0]       wr_data;
  logic [DATA_W-1:0]       rdata, mem_wdata;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    done, stall, hit, mem_req, mem_we;

  // Lookup uses the live address only in IDLE; afterwards the latched copy.
  assign cur_word = (state_q == S_IDLE) ? bus.addr[ADDR_W-1:1] : addr_q;
  assign cur_off  = cur_word[OFFSET_BITS-1:0];
  assign cur_idx  = cur_word[IDX_LO+INDEX_BITS-1:IDX_LO];
  assign cur_tag  = cur_word[ADDR_W-2:IDX_LO+INDEX_BITS];

  dcache_array #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)) u_array (
    .clk       (clk),
    .rst       (rst),
    .idx       (cur_idx),
    .rd_tag    (a_tag),
    .rd_valid  (a_valid),
    .rd_dirty  (a_dirty),
    .rd_line   (a_line),
    .word_we   (word_we),
    .wr_off    (wr_off),
    .wr_data   (wr_data),
    .tag_we    (tag_we),
    .wr_tag    (cur_tag),
    .set_dirty (set_dirty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rdata     = '0;
    done      = 1'b0;
    stall     = 1'b0;
    hit       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    word_we   = 1'b0;
    tag_we    = 1'b0;
    set_dirty = 1'b0;
    wr_off    = cur_off;
    wr_data   = bus.wdata;
    req_bad   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if ((bus.rd || bus.wr) && (bus.addr[0] || (bus.rd && bus.wr))) begin
          req_bad = 1'b1;
        end else if (bus.rd || bus.wr) begin
          if (a_valid && (a_tag == cur_tag)) begin
            done = 1'b1;
            hit  = 1'b1;
            if (bus.rd) begin
              rdata = a_line[cur_off];
            end else begin
              word_we   = 1'b1;
              set_dirty = 1'b1;
            end
          end else begin
            stall   = 1'b1;
            addr_d  = bus.addr[ADDR_W-1:1];
            wr_d    = bus.wr;
            wdata_d = bus.wdata;
            cnt_d   = '0;
            tmo_d   = TMO_LOAD;
            state_d = (a_valid && a_dirty) ? S_WB : S_FILL;
          end
        end
      end
      S_WB, S_FILL: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (state_q == S_WB) begin
          mem_we    = 1'b1;
          mem_addr  = {a_tag, cur_idx, cnt_q, 1'b0};
          mem_wdata = a_line[cnt_q];
        end else begin
          mem_addr  = {cur_tag, cur_idx, cnt_q, 1'b0};
        end
        // A timed-out transfer freezes the FSM until reset.
        if (!err_q) begin
          if (bus.mem_ack) begin
            cnt_d = cnt_q + 1'b1;
            tmo_d = TMO_LOAD;
            if (state_q == S_FILL) begin
              word_we = 1'b1;
              wr_off  = cnt_q;
              wr_data = bus.mem_rdata;
            end
            if (cnt_q == LAST_WORD) begin
              if (state_q == S_WB) begin
                state_d = S_FILL;
              end else begin
                tag_we  = 1'b1;
                state_d = S_DONE;
              end
            end
          end else if (tmo_q == '0) begin
            err_d = 1'b1;
          end else begin
            tmo_d = tmo_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (wr_q) begin
          word_we   = 1'b1;
          wr_data   = wdata_q;
          set_dirty = 1'b1;
        end else begin
          rdata = a_line[cur_off];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.rdata     = rdata;
  assign bus.done      = done;
  assign bus.stall     = stall;
  assign bus.hit       = hit;
  assign bus.err       = err_q | req_bad;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a backing-memory model and transaction scoreboard.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  dcache_ctrl #(.INDEX_BITS(5), .MEM_TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic we; logic [15:0] a; logic [15:0] d;} mtx_t;
  typedef struct packed {logic is_rd; logic [15:0] rdata; logic hit;} res_t;
  mtx_t exp_q[$];
  res_t res_q[$];
  logic [15:0] mem_w [int];

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem_w.exists(int'(a))) return mem_w[int'(a)];
    return pat(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_fill(input logic [15:0] base);
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, base + 16'(2 * i), 16'h0});
  endtask

  task automatic push_wb(input logic [15:0] base, input logic [15:0] w0, w1, w2, w3);
    exp_q.push_back('{1'b1, base,         w0});
    exp_q.push_back('{1'b1, base + 16'd2, w1});
    exp_q.push_back('{1'b1, base + 16'd4, w2});
    exp_q.push_back('{1'b1, base + 16'd6, w3});
  endtask

  // Drives one access and serves the memory side until done (or stop_acks acks).
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d, input int delay,
                        input logic exp_hit, input logic [15:0] exp_rdata,
                        input int exp_lat, input int stop_acks);
    int wcnt = 0;
    int acks = 0;
    bit fin  = 0;
    logic [15:0] cap_a = '0;
    logic [15:0] cap_d = '0;
    res_t e;
    mtx_t m;
    if (stop_acks == 0) res_q.push_back('{r, exp_rdata, exp_hit});
    @(negedge clk);
    bus.rd = r; bus.wr = w; bus.addr = a; bus.wdata = d; bus.mem_ack = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      #1;
      if (bus.done) begin
        e = res_q.pop_front();
        check({tag, ":hit"},   32'(bus.hit),   32'(e.hit));
        check({tag, ":stall"}, 32'(bus.stall), 32'h0);
        check({tag, ":err"},   32'(bus.err),   32'h0);
        if (e.is_rd) check({tag, ":rdata"}, 32'(bus.rdata), 32'(e.rdata));
        check({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
        fin = 1;
        break;
      end
      check({tag, ":stall_hold"}, 32'(bus.stall), 32'h1);
      if (bus.mem_req) begin
        if (wcnt == 0) begin
          cap_a = bus.mem_addr;
          cap_d = bus.mem_wdata;
        end else begin
          check({tag, ":addr_stable"},  32'(bus.mem_addr),  32'(cap_a));
          check({tag, ":wdata_stable"}, 32'(bus.mem_wdata), 32'(cap_d));
        end
        if (wcnt == delay) begin
          if (exp_q.size() == 0) begin
            check({tag, ":extra_req"}, 32'(bus.mem_addr), 32'hFFFF_FFFF);
          end else begin
            m = exp_q.pop_front();
            check({tag, ":mem_we"},   32'(bus.mem_we),   32'(m.we));
            check({tag, ":mem_addr"}, 32'(bus.mem_addr), 32'(m.a));
            if (m.we) check({tag, ":mem_wdata"}, 32'(bus.mem_wdata), 32'(m.d));
          end
          if (bus.mem_we) mem_w[int'(bus.mem_addr)] = bus.mem_wdata;
          else            bus.mem_rdata = mem_rd(bus.mem_addr);
          bus.mem_ack = 1'b1;
          wcnt = 0;
          acks++;
        end else begin
          wcnt++;
        end
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (stop_acks > 0 && acks >= stop_acks) begin
        fin = 1;
        break;
      end
    end
    if (!fin) check({tag, ":no_done"}, 32'h0, 32'h1);
    if (stop_acks == 0) begin
      @(negedge clk);
      bus.rd = 1'b0; bus.wr = 1'b0;
      check({tag, ":sb_empty"}, 32'(exp_q.size()), 32'h0);
    end
  endtask

  initial begin
    int k;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst:done",      32'(bus.done),      32'h0);
    check("rst:stall",     32'(bus.stall),     32'h0);
    check("rst:hit",       32'(bus.hit),       32'h0);
    check("rst:err",       32'(bus.err),       32'h0);
    check("rst:mem_req",   32'(bus.mem_req),   32'h0);
    check("rst:mem_we",    32'(bus.mem_we),    32'h0);
    check("rst:rdata",     32'(bus.rdata),     32'h0);
    check("rst:mem_addr",  32'(bus.mem_addr),  32'h0);
    check("rst:mem_wdata", 32'(bus.mem_wdata), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    push_fill(16'h0100);
    access("cold_rd", 1, 0, 16'h0104, 16'h0, 0, 0, pat(16'h0104), 5, 0);
    access("rep_hit", 1, 0, 16'h0104, 16'h0, 0, 1, pat(16'h0104), 0, 0);
    access("wr_hit",  0, 1, 16'h0104, 16'hBEEF, 0, 1, 16'h0, 0, 0);
    access("rd_beef", 1, 0, 16'h0104, 16'h0, 0, 1, 16'hBEEF, 0, 0);
    access("oth_word", 1, 0, 16'h0106, 16'h0, 0, 1, pat(16'h0106), 0, 0);

    push_wb(16'h0100, pat(16'h0100), pat(16'h0102), 16'hBEEF, pat(16'h0106));
    push_fill(16'h2100);
    access("evict", 1, 0, 16'h2104, 16'h0, 0, 0, pat(16'h2104), 9, 0);

    push_fill(16'h0008);
    access("wr_miss", 0, 1, 16'h0008, 16'h1234, 0, 0, 16'h0, 5, 0);
    access("wr_miss_rd", 1, 0, 16'h0008, 16'h0, 0, 1, 16'h1234, 0, 0);
    push_wb(16'h0008, 16'h1234, pat(16'h000A), pat(16'h000C), pat(16'h000E));
    push_fill(16'h2008);
    access("conflict", 1, 0, 16'h200A, 16'h0, 0, 0, pat(16'h200A), 9, 0);
    push_fill(16'h0008);
    access("reload", 1, 0, 16'h0008, 16'h0, 0, 0, 16'h1234, 5, 0);

    push_fill(16'h0010);
    access("slow", 1, 0, 16'h0016, 16'h0, 5, 0, pat(16'h0016), 25, 0);

    @(negedge clk);
    bus.rd = 1'b1; bus.addr = 16'h0003;
    #1;
    check("unal:err",     32'(bus.err),     32'h1);
    check("unal:done",    32'(bus.done),    32'h0);
    check("unal:stall",   32'(bus.stall),   32'h0);
    check("unal:mem_req", 32'(bus.mem_req), 32'h0);
    @(negedge clk);
    #1;
    check("unal:mem_req2", 32'(bus.mem_req), 32'h0);
    bus.wr = 1'b1; bus.addr = 16'h0016;
    #1;
    check("rdwr:err",     32'(bus.err),     32'h1);
    check("rdwr:done",    32'(bus.done),    32'h0);
    check("rdwr:mem_req", 32'(bus.mem_req), 32'h0);
    @(negedge clk);
    bus.rd = 1'b0; bus.wr = 1'b0;
    #1;
    check("idle:err",  32'(bus.err),  32'h0);
    check("idle:done", 32'(bus.done), 32'h0);
    access("post_err", 1, 0, 16'h0016, 16'h0, 0, 1, pat(16'h0016), 0, 0);

    push_fill(16'h0030);
    access("part_fill", 1, 0, 16'h0030, 16'h0, 0, 0, 16'h0, 0, 2);
    exp_q.delete();
    rst = 1'b0; bus.rd = 1'b0;
    #1;
    check("midrst:mem_req", 32'(bus.mem_req), 32'h0);
    check("midrst:stall",   32'(bus.stall),   32'h0);
    check("midrst:state",   32'(dut.state_q), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b1;
    push_fill(16'h0030);
    access("refill", 1, 0, 16'h0032, 16'h0, 0, 0, pat(16'h0032), 5, 0);
    push_fill(16'h0010);
    access("inval", 1, 0, 16'h0016, 16'h0, 0, 0, pat(16'h0016), 5, 0);

    @(negedge clk);
    bus.rd = 1'b1; bus.addr = 16'h0040;
    k = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (k < 0) begin
        if (bus.mem_req) k = 0;
      end else begin
        k++;
        if (bus.err) break;
      end
    end
    check("tmo:latency", 32'(k), 32'd255);
    repeat (20) @(negedge clk);
    #1;
    check("tmo:sticky",  32'(bus.err),     32'h1);
    check("tmo:mem_req", 32'(bus.mem_req), 32'h1);
    check("tmo:stall",   32'(bus.stall),   32'h1);
    rst = 1'b0; bus.rd = 1'b0;
    #1;
    check("tmo:rst_err", 32'(bus.err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the memory stage and a single-ported backing data memory.
- Presents a hit/stall interface to the memory stage. While a miss is serviced, its stall output drives the pipeline-wide data-memory stall (EX/MEM and ID/EX enables, fetch hold).
- Holds tag/valid/dirty/data arrays internally as registers and runs a line writeback/refill state machine with a word counter.

Parameters:
- INDEX_BITS, 5: line index width; 2**INDEX_BITS lines.
- MEM_TIMEOUT, 255: max cycles waiting on mem_ack before err asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd  in  1  memory-stage read request.
- wr  in  1  memory-stage write request (rd & wr together is illegal → err).
- addr  in  16  byte address.
- wdata  in  16  store data.
- rdata  out  16  load data, valid when done & was-read.
- done  out  1  access completes this cycle.
- stall  out  1  pipeline must hold the memory-stage request.
- hit  out  1  the access completing this cycle hit without a fill.
- err  out  1  unaligned address, rd&wr, or memory timeout.
- mem_req  out  1  backing memory request; held until mem_ack.
- mem_we  out  1  1 = write word, 0 = read word.
- mem_addr  out  16  word-aligned backing address.
- mem_wdata  out  16  writeback data.
- mem_ack  in  1  backing memory completes the current word.
- mem_rdata  in  16  refill data, valid with mem_ack on reads.

Behaviour:
- Address split:
  - tag = addr[15:INDEX_BITS+3]
  - index = addr[INDEX_BITS+2:3]
  - word offset = addr[2:1]
  - addr[0] must be 0
- Line size is 4 words.
- Reset (rst low, asynchronous):
  - state = IDLE; all valid and dirty bits cleared; word counter 0; timeout counter 0.
  - Outputs: done, stall, hit, err, mem_req and mem_we are 0; rdata, mem_addr and mem_wdata are 0.
  - Data and tag arrays need no reset.
- IDLE / compare state:
  - Lookup is combinational.
  - Hit (rd|wr, valid, tag match): done=1, hit=1, stall=0 in the same cycle. Zero-cycle latency.
  - Read hit: rdata = array word.
  - Write hit: word written and dirty set at the clock edge.
  - Miss: stall=1 combinationally in the same cycle.
    - Go to WB if the victim line is valid and dirty, else go to FILL.
    - Word counter cleared; the request address is latched.
- WB:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, cnt, 1'b0}, mem_wdata = victim word cnt.
  - On mem_ack, cnt++. After word 3 is acked, go to FILL with cnt=0.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {req tag, index, cnt, 1'b0}.
  - On mem_ack, mem_rdata is written to word cnt and cnt++.
  - After word 3: tag written, valid=1, dirty=0, go to DONE.
- DONE (one cycle):
  - Access completes from the refilled line: done=1, hit=0, stall=0.
  - A write merges wdata and sets dirty.
  - Return to IDLE.
- stall is 1 in WB and FILL, and in IDLE on a miss; it is 0 in DONE.
- The pipeline holds rd/wr/addr/wdata stable while stall=1. The controller uses its latched copy regardless.
- mem_req is held high until mem_ack. Only one word is outstanding at a time; mem_addr and mem_wdata are stable while mem_req is high.
- The word counter is 2 bits and wraps at 3→0 on the final ack; the transition is taken on that ack.
- err cases:
  - rd|wr with addr[0]=1, or rd&wr: err=1 combinationally; no array update, no state change, done=0, stall=0.
  - No mem_ack within MEM_TIMEOUT cycles of mem_req rising: err=1 sticky until reset; FSM stays in its state.
- No requests (rd=wr=0) in IDLE: all outputs 0. An idle cycle never changes the arrays.
- Reset mid-WB/FILL: FSM aborts to IDLE, mem_req drops immediately, and all lines are invalidated. Memory may hold a partially written line; this is acceptable.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, WB, FILL, DONE)
  - LINE_WORDS=4, OFFSET_BITS=2
  - the address-field slicing helper constants
- One natural sub-module, dcache_array: tag/valid/dirty/data register arrays.
  - Combinational read by index.
  - Synchronous word write, tag write, and valid/dirty updates.
  - Asynchronous active-low clear of valid/dirty.
- The FSM, counters and handshake live in dcache_ctrl.

Test Plan:
- Cold read miss, clean: rd addr 0x0104 after reset.
  - Expect 4 read reqs: mem_addr 0x0100, 0x0102, 0x0104, 0x0106.
  - stall=1 throughout; then DONE with rdata = word returned for 0x0104, hit=0.
  - A repeat read of 0x0104 gives done=hit=1, stall=0 in the same cycle.
- Write hit then dirty eviction:
  - Write 0xBEEF to 0x0104 (hit, sets dirty).
  - Read 0x2104 (same index, different tag).
  - Expect 4 write reqs 0x0100–0x0106 carrying the line with 0xBEEF at 0x0104, then 4 reads 0x2100–0x2106, then done.
- Write miss allocate:
  - Write 0x1234 to cold 0x0008.
  - Expect a fill of 0x0008–0x000E, then DONE.
  - A later read of 0x0008 hits and returns 0x1234; the line is dirty, so a subsequent conflicting access writes it back.
- Slow memory:
  - mem_ack delayed 5 cycles per word.
  - Expect mem_req, mem_addr and mem_wdata stable during the wait and stall held.
  - Total miss latency is 4×6 cycles plus DONE.
- Error cases:
  - rd with addr 0x0003 → err=1, done=0, no mem_req.
  - rd=wr=1 → err=1.
  - mem_ack never asserted → err rises after 255 cycles and stays.
- Reset mid-FILL:
  - Assert rst low after the 2nd ack.
  - Expect mem_req=0 immediately and state IDLE.
  - After release, a read of the same address misses and refills all 4 words.
